multi_counter_bank: RTL and testbench

- Parametrised bank of NUM_CH independent up/down counters that share one clock.
- Per-channel enable, direction, load and terminal-count flags; a global clear; a sticky overflow flag per channel.
- An atomic snapshot register captures every channel in the same cycle.
- Supersedes the fixed two-instance 8-bit counter pair. Packed output ordering is unchanged: channel 0 in the MSBs.

---
 rtl/multi_counter_bank.sv | 92 +++++++++
 tb/tb_multi_counter_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_counter_bank.sv
// Bank of independent up/down counters with load, clear, sticky overflow
// and an atomic all-channel snapshot register. Channel 0 packs into the MSBs.
module multi_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic                    snap,
    output logic [NUM_CH*WIDTH-1:0] result,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH*WIDTH-1:0] snap_result,
    output logic                    snap_valid
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [NUM_CH*WIDTH-1:0] r_snap;
    logic                    r_snap_vld;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int HI = (NUM_CH - gi) * WIDTH - 1;

        logic [WIDTH-1:0] r_cnt;
        logic             r_tc;
        logic             r_ovf;
        logic [WIDTH-1:0] w_ld;
        logic [WIDTH-1:0] w_step;
        logic             w_bound;

        assign w_ld    = load_val[HI -: WIDTH];
        assign w_bound = up[gi] ? (r_cnt == MAX_VAL) : (r_cnt == '0);
        // Plain modulo step also yields the wrap value at either boundary
        assign w_step  = up[gi] ? r_cnt + 1'b1 : r_cnt - 1'b1;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_tc  <= 1'b0;
                r_ovf <= 1'b0;
            end else if (clear) begin
                r_cnt <= '0;
                r_tc  <= 1'b0;
                r_ovf <= 1'b0;
            end else if (load[gi]) begin
                r_cnt <= w_ld;
                r_tc  <= 1'b0;
            end else if (en[gi]) begin
                if (w_bound) begin
                    r_tc  <= 1'b1;
                    r_ovf <= 1'b1;
                    if (!SATURATE) begin
                        r_cnt <= w_step;
                    end
                end else begin
                    r_cnt <= w_step;
                    r_tc  <= 1'b0;
                end
            end else begin
                r_tc <= 1'b0;
            end
        end

        assign result[HI -: WIDTH] = r_cnt;
        assign tc[gi]              = r_tc;
        assign ovf[gi]             = r_ovf;
    end

    // Capture the pre-edge values of every channel in one shot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap     <= '0;
            r_snap_vld <= 1'b0;
        end else begin
            r_snap_vld <= snap;
            if (snap) begin
                r_snap <= result;
            end
        end
    end

    assign snap_result = r_snap;
    assign snap_valid  = r_snap_vld;

endmodule

// File: tb/tb_multi_counter_bank.sv
// Directed bench for multi_counter_bank: wrap, saturate and wide
// configurations instantiated side by side, driven in sequence.
module tb_multi_counter_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Wrap instance, WIDTH=8, NUM_CH=2
    logic        a_rst = 1'b1, a_clear = 1'b0, a_snap = 1'b0;
    logic [1:0]  a_en = '0, a_up = '0, a_load = '0;
    logic [15:0] a_lv = '0;
    logic [15:0] a_res, a_sres;
    logic [1:0]  a_tc, a_ovf;
    logic        a_sv;

    // Saturating instance, WIDTH=8, NUM_CH=2
    logic        b_rst = 1'b1, b_clear = 1'b0, b_snap = 1'b0;
    logic [1:0]  b_en = '0, b_up = '0, b_load = '0;
    logic [15:0] b_lv = '0;
    logic [15:0] b_res, b_sres;
    logic [1:0]  b_tc, b_ovf;
    logic        b_sv;

    // Wide instance, WIDTH=12, NUM_CH=4
    logic        c_rst = 1'b1, c_clear = 1'b0, c_snap = 1'b0;
    logic [3:0]  c_en = '0, c_up = '0, c_load = '0;
    logic [47:0] c_lv = '0;
    logic [47:0] c_res, c_sres;
    logic [3:0]  c_tc, c_ovf;
    logic        c_sv;

    multi_counter_bank #(.WIDTH(8), .NUM_CH(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(a_rst), .clear(a_clear), .en(a_en), .up(a_up),
        .load(a_load), .load_val(a_lv), .snap(a_snap), .result(a_res),
        .tc(a_tc), .ovf(a_ovf), .snap_result(a_sres), .snap_valid(a_sv)
    );

    multi_counter_bank #(.WIDTH(8), .NUM_CH(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(b_rst), .clear(b_clear), .en(b_en), .up(b_up),
        .load(b_load), .load_val(b_lv), .snap(b_snap), .result(b_res),
        .tc(b_tc), .ovf(b_ovf), .snap_result(b_sres), .snap_valid(b_sv)
    );

    multi_counter_bank #(.WIDTH(12), .NUM_CH(4), .SATURATE(1'b0)) u_wide (
        .clk(clk), .rst(c_rst), .clear(c_clear), .en(c_en), .up(c_up),
        .load(c_load), .load_val(c_lv), .snap(c_snap), .result(c_res),
        .tc(c_tc), .ovf(c_ovf), .snap_result(c_sres), .snap_valid(c_sv)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Reset state
        check("a_rst_res", 64'(a_res), 64'h0);
        check("a_rst_tc", 64'(a_tc), 64'h0);
        check("a_rst_ovf", 64'(a_ovf), 64'h0);
        check("a_rst_sres", 64'(a_sres), 64'h0);
        check("a_rst_sv", 64'(a_sv), 64'h0);

        // Both channels up for three cycles
        a_en = 2'b11; a_up = 2'b11;
        repeat (3) step();
        check("a_cnt3_res", 64'(a_res), 64'h0303);
        check("a_cnt3_tc", 64'(a_tc), 64'h0);
        check("a_cnt3_ovf", 64'(a_ovf), 64'h0);

        // Wrap of ch0 from FE
        a_en = 2'b00; a_load = 2'b01; a_lv = 16'hFE00;
        step();
        check("a_ld_fe", 64'(a_res), 64'hFE03);
        a_load = 2'b00; a_en = 2'b01; a_up = 2'b01;
        step();
        check("a_ff_res", 64'(a_res), 64'hFF03);
        check("a_ff_tc", 64'(a_tc), 64'h0);
        step();
        check("a_wrap_res", 64'(a_res), 64'h0003);
        check("a_wrap_tc", 64'(a_tc), 64'h1);
        check("a_wrap_ovf", 64'(a_ovf), 64'h1);
        a_en = 2'b00;
        step();
        check("a_hold_tc", 64'(a_tc), 64'h0);
        check("a_sticky_ovf", 64'(a_ovf), 64'h1);

        // Load beats enable on ch0 at FF; ch1 keeps counting
        a_load = 2'b01; a_lv = 16'hFF00;
        step();
        check("a_ld_ff", 64'(a_res), 64'hFF03);
        a_load = 2'b01; a_en = 2'b11; a_up = 2'b11; a_lv = 16'h4000;
        step();
        check("a_ld_en_res", 64'(a_res), 64'h4004);
        check("a_ld_en_tc", 64'(a_tc), 64'h0);

        // Snapshot together with clear captures pre-clear values
        a_load = 2'b11; a_en = 2'b00; a_lv = 16'h0507;
        step();
        check("a_ld_0507", 64'(a_res), 64'h0507);
        a_load = 2'b00; a_snap = 1'b1; a_clear = 1'b1;
        step();
        check("a_sc_res", 64'(a_res), 64'h0);
        check("a_sc_sres", 64'(a_sres), 64'h0507);
        check("a_sc_sv", 64'(a_sv), 64'h1);
        check("a_sc_ovf", 64'(a_ovf), 64'h0);
        a_snap = 1'b0; a_clear = 1'b0;
        step();
        check("a_sc_sv_off", 64'(a_sv), 64'h0);
        check("a_sc_hold", 64'(a_sres), 64'h0507);

        // Back-to-back snapshots while counting
        a_en = 2'b11; a_up = 2'b11; a_snap = 1'b1;
        step();
        check("a_bb1_sres", 64'(a_sres), 64'h0000);
        check("a_bb1_sv", 64'(a_sv), 64'h1);
        step();
        check("a_bb2_sres", 64'(a_sres), 64'h0101);
        check("a_bb2_sv", 64'(a_sv), 64'h1);
        check("a_bb2_res", 64'(a_res), 64'h0202);
        a_snap = 1'b0; a_en = 2'b00;
        step();
        check("a_bb_end_sv", 64'(a_sv), 64'h0);

        // Wrap-mode underflow on ch1 from 0
        a_clear = 1'b1;
        step();
        a_clear = 1'b0; a_en = 2'b10; a_up = 2'b00;
        step();
        check("a_dn_res", 64'(a_res), 64'h00FF);
        check("a_dn_tc", 64'(a_tc), 64'h2);
        check("a_dn_ovf", 64'(a_ovf), 64'h2);
        a_en = 2'b00;

        // Saturating down on ch1 from 01
        b_load = 2'b10; b_lv = 16'h0001;
        step();
        check("b_ld", 64'(b_res), 64'h0001);
        b_load = 2'b00; b_en = 2'b10; b_up = 2'b00;
        step();
        check("b_c1_res", 64'(b_res), 64'h0000);
        check("b_c1_tc", 64'(b_tc), 64'h0);
        step();
        check("b_c2_res", 64'(b_res), 64'h0000);
        check("b_c2_tc", 64'(b_tc), 64'h2);
        check("b_c2_ovf", 64'(b_ovf), 64'h2);
        step();
        check("b_c3_res", 64'(b_res), 64'h0000);
        check("b_c3_tc", 64'(b_tc), 64'h2);
        b_en = 2'b00; b_clear = 1'b1;
        step();
        check("b_clr_res", 64'(b_res), 64'h0);
        check("b_clr_ovf", 64'(b_ovf), 64'h0);
        check("b_clr_tc", 64'(b_tc), 64'h0);

        // Saturating up on ch0 at FF holds
        b_clear = 1'b0; b_load = 2'b01; b_lv = 16'hFF00;
        step();
        b_load = 2'b00; b_en = 2'b01; b_up = 2'b01;
        step();
        check("b_up_res", 64'(b_res), 64'hFF00);
        check("b_up_tc", 64'(b_tc), 64'h1);
        check("b_up_ovf", 64'(b_ovf), 64'h1);
        b_en = 2'b00;

        // Wide: ch2 down from 0, others hold, then rst mid-run
        c_en = 4'b0100; c_up = 4'b0000;
        step();
        check("c_dn1_res", c_res, 64'h0000_0000_0FFF_000);
        check("c_dn1_tc", 64'(c_tc), 64'h4);
        check("c_dn1_ovf", 64'(c_ovf), 64'h4);
        step();
        check("c_dn2_res", c_res, 64'h0000_0000_0FFE_000);
        check("c_dn2_tc", 64'(c_tc), 64'h0);
        c_snap = 1'b1;
        step();
        check("c_snap_sres", c_sres, 64'h0000_0000_0FFE_000);
        check("c_snap_sv", 64'(c_sv), 64'h1);
        c_rst = 1'b1;
        step();
        check("c_rst_res", c_res, 64'h0);
        check("c_rst_tc", 64'(c_tc), 64'h0);
        check("c_rst_ovf", 64'(c_ovf), 64'h0);
        check("c_rst_sres", c_sres, 64'h0);
        check("c_rst_sv", 64'(c_sv), 64'h0);
        c_rst = 1'b0; c_snap = 1'b0; c_en = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
